// File: rtl/lda16_load_sequencer_pkg.sv
// rtl/lda16_load_sequencer_pkg.sv - shared constants and types for the LD A,(a16) sequencer
package lda16_load_sequencer_pkg;

    localparam int LDA16_ADDR_W = 16;
    localparam int LDA16_DATA_W = 8;
    localparam int T_STEPS      = 4;

    localparam logic [7:0] LDA_A16_OPC = 8'hFA;

    typedef logic [1:0] mstate_t;
    typedef logic [1:0] tstep_t;

    localparam mstate_t ST_IDLE   = 2'd0;
    localparam mstate_t ST_IMM_LO = 2'd1;
    localparam mstate_t ST_IMM_HI = 2'd2;
    localparam mstate_t ST_DATA   = 2'd3;

    localparam tstep_t TSTEP_T0 = 2'd0;
    localparam tstep_t TSTEP_T1 = 2'd1;
    localparam tstep_t TSTEP_T2 = 2'd2;
    localparam tstep_t TSTEP_T3 = 2'd3;

    // One-hot views of the T-steps for sequencers that decode per step.
    localparam logic [3:0] TSTEP_T0_OH = 4'b0001;
    localparam logic [3:0] TSTEP_T1_OH = 4'b0010;
    localparam logic [3:0] TSTEP_T2_OH = 4'b0100;
    localparam logic [3:0] TSTEP_T3_OH = 4'b1000;

    typedef struct packed {
        logic pc_inc;
        logic a_write;
        logic ir_fetch;
    } strobes_t;

endpackage

// File: rtl/lda16_load_sequencer_if.sv
// rtl/lda16_load_sequencer_if.sv - decode handshake and memory read bus of the load sequencer
interface lda16_load_sequencer_if
    import lda16_load_sequencer_pkg::*;
#(
    parameter int ADDR_W = LDA16_ADDR_W,
    parameter int DATA_W = LDA16_DATA_W
);
    logic              i_Start;
    logic [ADDR_W-1:0] i_PC;
    logic [DATA_W-1:0] i_Mem_Data;
    logic              i_Mem_Wait;
    logic              o_Busy;
    logic [ADDR_W-1:0] o_Mem_Addr;
    logic              o_Mem_Rd;
    logic              o_PC_Inc;
    logic              o_A_Write;
    logic [DATA_W-1:0] o_A_Data;
    logic              o_IR_Fetch;

    modport master (
        output i_Start, i_PC, i_Mem_Data, i_Mem_Wait,
        input  o_Busy, o_Mem_Addr, o_Mem_Rd, o_PC_Inc, o_A_Write, o_A_Data, o_IR_Fetch
    );

    modport slave (
        input  i_Start, i_PC, i_Mem_Data, i_Mem_Wait,
        output o_Busy, o_Mem_Addr, o_Mem_Rd, o_PC_Inc, o_A_Write, o_A_Data, o_IR_Fetch
    );
endinterface

// File: rtl/lda16_load_sequencer_mcycle_step_counter.sv
// rtl/lda16_load_sequencer_mcycle_step_counter.sv - T0..T3 step counter with T2 memory-wait stall
module lda16_load_sequencer_mcycle_step_counter
    import lda16_load_sequencer_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   clear_i,
    input  logic   stall_i,
    output tstep_t step_o,
    output logic   last_o
);
    tstep_t step_q;
    tstep_t step_d;

    // Wait only stretches the sample step; elsewhere it is ignored.
    always_comb begin
        step_d = step_q;
        if (clear_i) begin
            step_d = TSTEP_T0;
        end else if (!(stall_i && (step_q == TSTEP_T2))) begin
            step_d = step_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            step_q <= TSTEP_T0;
        end else begin
            step_q <= step_d;
        end
    end

    assign step_o = step_q;
    assign last_o = (step_q == TSTEP_T3);
endmodule

// File: rtl/lda16_load_sequencer.sv
// rtl/lda16_load_sequencer.sv - LD A,(a16) sequencer: fetch two immediates, read the byte, write A
module lda16_load_sequencer
    import lda16_load_sequencer_pkg::*;
#(
    parameter int ADDR_W = LDA16_ADDR_W,
    parameter int DATA_W = LDA16_DATA_W
)(
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    lda16_load_sequencer_if.slave  bus
);
    mstate_t           state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] a_hold_q, a_hold_d;

    tstep_t            step;
    logic              step_last;
    logic              busy;
    logic              rd;
    logic              sample;
    logic [ADDR_W-1:0] mem_addr;
    strobes_t          strb;

    lda16_load_sequencer_mcycle_step_counter u_mcycle_step_counter (
        .clk_i   (i_Clk),
        .rst_i   (i_Reset),
        .clear_i (state_q == ST_IDLE),
        .stall_i (bus.i_Mem_Wait),
        .step_o  (step),
        .last_o  (step_last)
    );

    assign busy   = (state_q != ST_IDLE);
    assign rd     = busy && !step_last;
    assign sample = busy && (step == TSTEP_T2) && !bus.i_Mem_Wait;

    always_comb begin
        mem_addr = '0;
        if (rd) begin
            mem_addr = (state_q == ST_DATA) ? {hi_q, lo_q} : ptr_q;
        end
    end

    always_comb begin
        strb = '0;
        if (busy && step_last) begin
            case (state_q)
                ST_IMM_LO, ST_IMM_HI: strb.pc_inc = 1'b1;
                ST_DATA: begin
                    strb.a_write  = 1'b1;
                    strb.ir_fetch = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        data_d   = data_q;
        a_hold_d = a_hold_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_Start) begin
                    state_d = ST_IMM_LO;
                    ptr_d   = bus.i_PC;
                end
            end
            ST_IMM_LO: begin
                if (sample) lo_d = bus.i_Mem_Data;
                if (step_last) begin
                    ptr_d   = ptr_q + ADDR_W'(1);
                    state_d = ST_IMM_HI;
                end
            end
            ST_IMM_HI: begin
                if (sample) hi_d = bus.i_Mem_Data;
                if (step_last) begin
                    ptr_d   = ptr_q + ADDR_W'(1);
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (sample) data_d = bus.i_Mem_Data;
                // Retain the committed byte so o_A_Data stays put until the next write.
                if (step_last) begin
                    a_hold_d = data_q;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            data_q   <= '0;
            a_hold_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            data_q   <= data_d;
            a_hold_q <= a_hold_d;
        end
    end

    assign bus.o_Busy     = busy;
    assign bus.o_Mem_Rd   = rd;
    assign bus.o_Mem_Addr = mem_addr;
    assign bus.o_PC_Inc   = strb.pc_inc;
    assign bus.o_A_Write  = strb.a_write;
    assign bus.o_IR_Fetch = strb.ir_fetch;
    assign bus.o_A_Data   = strb.a_write ? data_q : a_hold_q;
endmodule

// File: tb/tb_lda16_load_sequencer.sv
// tb/tb_lda16_load_sequencer.sv - scoreboard bench for the LD A,(a16) load sequencer
module tb_lda16_load_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lda16_load_sequencer_if bus ();

    lda16_load_sequencer dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } wr_exp_t;

    logic [7:0]  mem [0:65535];
    logic [15:0] exp_addr_q [$];
    wr_exp_t     exp_wr_q [$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_mark = 0;
    int pc_cnt = 0;
    int irf_cnt = 0;
    logic prev_rd = 1'b0;

    assign bus.i_Mem_Data = mem[bus.o_Mem_Addr];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [15:0] ea;
        wr_exp_t     w;
        if (rst) begin
            prev_rd = 1'b0;
        end else begin
            if (bus.o_Mem_Rd && !prev_rd) begin
                total++;
                if (exp_addr_q.size() == 0) begin
                    bad++;
                    $display("FAIL rd_addr: unexpected read at %h, none expected", bus.o_Mem_Addr);
                end else begin
                    ea = exp_addr_q.pop_front();
                    if (bus.o_Mem_Addr !== ea) begin
                        bad++;
                        $display("FAIL rd_addr: got %h expected %h", bus.o_Mem_Addr, ea);
                    end
                end
            end
            prev_rd = bus.o_Mem_Rd;
            if (bus.o_PC_Inc) pc_cnt++;
            if (bus.o_IR_Fetch) irf_cnt++;
            if (bus.o_A_Write) begin
                total++;
                if (exp_wr_q.size() == 0) begin
                    bad++;
                    $display("FAIL a_write: unexpected write of %h, none expected", bus.o_A_Data);
                end else begin
                    w = exp_wr_q.pop_front();
                    if (bus.o_A_Data !== w.data || (cyc - start_mark) != w.cyc) begin
                        bad++;
                        $display("FAIL a_write: got data %h cycle %0d expected data %h cycle %0d",
                                 bus.o_A_Data, cyc - start_mark, w.data, w.cyc);
                    end
                end
            end
            total++;
            assert (bus.o_Mem_Rd || bus.o_Mem_Addr == 16'h0000)
            else begin
                bad++;
                $display("FAIL addr_idle: o_Mem_Addr=%h with o_Mem_Rd=0 expected 0000", bus.o_Mem_Addr);
            end
        end
    end

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            bus.i_Start    = 1'b0;
            bus.i_Mem_Wait = 1'b0;
        end
    endtask

    task automatic drive_instr(input logic [15:0] pc, input int ws, input int wl,
                               input logic [15:0] wait_addr, input int exp_cyc,
                               input int rst_cyc, input int ign1, input int ign2);
        logic [15:0] hi_a;
        logic [15:0] a16;
        logic [28:0] outs;
        wr_exp_t     w;
        int          last;
        @(negedge clk);
        total++;
        if (bus.o_Busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_before_start: o_Busy=%b expected 0", bus.o_Busy);
        end
        hi_a = pc + 16'd1;
        a16  = {mem[hi_a], mem[pc]};
        exp_addr_q.push_back(pc);
        exp_addr_q.push_back(hi_a);
        exp_addr_q.push_back(a16);
        if (rst_cyc == 0) begin
            w.data = mem[a16];
            w.cyc  = exp_cyc;
            exp_wr_q.push_back(w);
        end
        pc_cnt = 0;
        irf_cnt = 0;
        bus.i_Start = 1'b1;
        bus.i_PC    = pc;
        @(posedge clk);
        #1;
        start_mark = cyc - 1;
        last = (rst_cyc > 0) ? rst_cyc : exp_cyc;
        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            bus.i_Start    = (n == ign1) || (n == ign2);
            bus.i_PC       = 16'h2000;
            bus.i_Mem_Wait = (n >= ws) && (n < ws + wl);
            if (wl > 0 && n >= ws && n <= ws + wl) begin
                total++;
                if (bus.o_Mem_Addr !== wait_addr) begin
                    bad++;
                    $display("FAIL wait_addr: cycle %0d got %h expected %h", n, bus.o_Mem_Addr, wait_addr);
                end
            end
            if (n == rst_cyc) begin
                #2 rst = 1'b1;
                #1;
                outs = {bus.o_Busy, bus.o_Mem_Rd, bus.o_PC_Inc, bus.o_A_Write, bus.o_IR_Fetch,
                        bus.o_Mem_Addr, bus.o_A_Data};
                total++;
                if (outs !== 29'd0) begin
                    bad++;
                    $display("FAIL reset_mid_outputs: got %h expected 0", outs);
                end
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
            end
        end
    endtask

    task automatic check_run(input string name, input int exp_pc, input int exp_irf);
        total++;
        if (pc_cnt != exp_pc || irf_cnt != exp_irf) begin
            bad++;
            $display("FAIL %s_strobes: pc_inc=%0d ir_fetch=%0d expected %0d %0d",
                     name, pc_cnt, irf_cnt, exp_pc, exp_irf);
        end
        total++;
        if (exp_addr_q.size() != 0 || exp_wr_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: reads left %0d writes left %0d expected 0 0",
                     name, exp_addr_q.size(), exp_wr_q.size());
        end
    endtask

    task automatic test_reset;
        logic [28:0] outs;
        rst = 1'b1;
        bus.i_Start = 1'b0;
        bus.i_PC = 16'h0000;
        bus.i_Mem_Wait = 1'b0;
        repeat (3) @(negedge clk);
        outs = {bus.o_Busy, bus.o_Mem_Rd, bus.o_PC_Inc, bus.o_A_Write, bus.o_IR_Fetch,
                bus.o_Mem_Addr, bus.o_A_Data};
        total++;
        if (outs !== 29'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        rst = 1'b0;
        idle(2);
        outs = {bus.o_Busy, bus.o_Mem_Rd, bus.o_PC_Inc, bus.o_A_Write, bus.o_IR_Fetch,
                bus.o_Mem_Addr, bus.o_A_Data};
        total++;
        if (outs !== 29'd0) begin
            bad++;
            $display("FAIL post_reset_idle: got %h expected 0", outs);
        end
    endtask

    task automatic load_basic_mem;
        mem[16'h0100] = 8'h34;
        mem[16'h0101] = 8'h12;
        mem[16'h1234] = 8'hA5;
    endtask

    task automatic test_basic;
        load_basic_mem();
        drive_instr(16'h0100, 0, 0, 16'h0000, 12, 0, 0, 0);
        idle(3);
        check_run("basic", 2, 1);
        total++;
        if (bus.o_A_Data !== 8'hA5) begin
            bad++;
            $display("FAIL a_data_hold: got %h expected a5", bus.o_A_Data);
        end
    endtask

    task automatic test_wait_imm_hi;
        drive_instr(16'h0100, 7, 3, 16'h0101, 15, 0, 0, 0);
        idle(3);
        check_run("wait_imm_hi", 2, 1);
    endtask

    task automatic test_wait_outside_t2;
        drive_instr(16'h0100, 1, 2, 16'h0100, 12, 0, 0, 0);
        idle(3);
        check_run("wait_outside_t2", 2, 1);
    endtask

    task automatic test_wrap;
        mem[16'hFFFF] = 8'h00;
        mem[16'h0000] = 8'hC0;
        mem[16'hC000] = 8'h5A;
        drive_instr(16'hFFFF, 0, 0, 16'h0000, 12, 0, 0, 0);
        idle(3);
        check_run("wrap", 2, 1);
        mem[16'h0000] = 8'h00;
    endtask

    task automatic test_reset_mid;
        load_basic_mem();
        drive_instr(16'h0100, 0, 0, 16'h0000, 12, 10, 0, 0);
        idle(3);
        check_run("reset_mid", 2, 0);
        drive_instr(16'h0100, 0, 0, 16'h0000, 12, 0, 0, 0);
        idle(3);
        check_run("after_reset", 2, 1);
    endtask

    task automatic test_back_to_back;
        drive_instr(16'h0100, 0, 0, 16'h0000, 12, 0, 6, 12);
        drive_instr(16'h0100, 0, 0, 16'h0000, 12, 0, 0, 0);
        idle(3);
        check_run("back_to_back", 2, 1);
    endtask

    task automatic test_top_byte;
        mem[16'h0300] = 8'hFF;
        mem[16'h0301] = 8'hFF;
        mem[16'hFFFF] = 8'hFF;
        drive_instr(16'h0300, 0, 0, 16'h0000, 12, 0, 0, 0);
        idle(3);
        check_run("top_byte", 2, 1);
        total++;
        if (bus.o_A_Data !== 8'hFF) begin
            bad++;
            $display("FAIL top_byte_data: got %h expected ff", bus.o_A_Data);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        test_reset();
        test_basic();
        test_wait_imm_hi();
        test_wait_outside_t2();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        test_top_byte();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
